// File: rtl/bank_response_collector.sv
// Purpose: round-robin collector of per-bank responses into a small output buffer, delivered one per cycle.
// Latency: 1 cycle from bank grant to out_valid; the head entry is read from registered storage.
// Backpressure: out_valid/out_ready to the front-end; one-hot bank_resp_ready withheld while the buffer cannot accept.
module bank_response_collector #(
    parameter int NUM_BANKS  = 16,
    parameter int DATA_W     = 16,
    parameter int INDEX_W    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [0:NUM_BANKS-1]                bank_resp_valid,
    input  logic [0:NUM_BANKS-1]                bank_resp_type,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_resp_data,
    input  logic [NUM_BANKS-1:0][INDEX_W-1:0]   bank_resp_index,
    output logic [0:NUM_BANKS-1]                bank_resp_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_type,
    output logic [DATA_W-1:0]                   out_data,
    output logic [INDEX_W-1:0]                  out_index,
    output logic [$clog2(NUM_BANKS)-1:0]        out_bank,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
    output logic                                fifo_full
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic               typ;
        logic [DATA_W-1:0]  data;
        logic [INDEX_W-1:0] index;
        logic [BANK_W-1:0]  bank;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head_entry;
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count;
    logic [BANK_W-1:0]  rr_ptr;

    logic               can_push;
    logic               pop;
    logic               grant_vld;
    logic [BANK_W-1:0]  grant_idx;
    logic [BANK_W-1:0]  cand;

    assign pop      = out_valid && out_ready;
    assign can_push = (count < CNT_W'(FIFO_DEPTH)) || pop;

    // Round-robin search from rr_ptr; the descending loop lets the nearest valid bank win.
    // Ready is also forced low while reset is asserted so no bank sees a grant during reset.
    always_comb begin
        grant_vld       = 1'b0;
        grant_idx       = '0;
        cand            = '0;
        bank_resp_ready = '0;
        if (can_push && rst) begin
            for (int off = NUM_BANKS - 1; off >= 0; off--) begin
                cand = rr_ptr + BANK_W'(off);
                if (bank_resp_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        bank_resp_ready[grant_idx] = grant_vld;
    end

    // Buffer storage: the granted bank's response is written at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (grant_vld) begin
            mem[tail_ptr] <= '{typ:   bank_resp_type[grant_idx],
                               data:  bank_resp_data[grant_idx],
                               index: bank_resp_index[grant_idx],
                               bank:  grant_idx};
        end
    end

    // Pointer, occupancy and round-robin bookkeeping; pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (grant_vld) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
                rr_ptr   <= grant_idx + BANK_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({grant_vld, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry = mem[head_ptr];
    assign out_valid  = (count != '0);
    assign out_type   = head_entry.typ;
    assign out_data   = head_entry.data;
    assign out_index  = head_entry.index;
    assign out_bank   = head_entry.bank;
    assign fifo_count = count;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_bank_response_collector.sv
// Purpose: directed cycle-by-cycle check of the bank response collector.
// Latency: each table row is one clock; expectations describe the cycle before the next rising edge.
// Backpressure: rows drive out_ready low to fill the buffer and confirm grants are withheld.
module tb_bank_response_collector;

    logic                 clk;
    logic                 rst;
    logic [0:15]          bank_resp_valid;
    logic [0:15]          bank_resp_type;
    logic [15:0][15:0]    bank_resp_data;
    logic [15:0][5:0]     bank_resp_index;
    logic [0:15]          bank_resp_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_type;
    logic [15:0]          out_data;
    logic [5:0]           out_index;
    logic [3:0]           out_bank;
    logic [2:0]           fifo_count;
    logic                 fifo_full;

    int tests_run = 0;
    int tests_failed = 0;

    bank_response_collector dut (
        .clk             (clk),
        .rst             (rst),
        .bank_resp_valid (bank_resp_valid),
        .bank_resp_type  (bank_resp_type),
        .bank_resp_data  (bank_resp_data),
        .bank_resp_index (bank_resp_index),
        .bank_resp_ready (bank_resp_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_type        (out_type),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_bank        (out_bank),
        .fifo_count      (fifo_count),
        .fifo_full       (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bank response contents; the expected out_* values are looked up here by bank.
    logic        m_type  [16];
    logic [15:0] m_data  [16];
    logic [5:0]  m_index [16];

    typedef struct {
        logic [15:0] vmask;     // bit i = bank i valid
        logic        ordy;
        logic [15:0] rmask;     // bit i = expected ready for bank i
        logic        exp_vld;
        logic [3:0]  exp_bank;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] vm, input logic o, input logic [15:0] rm,
                                input logic v, input logic [3:0] b, input logic [2:0] c);
        vec_t t;
        t.vmask = vm; t.ordy = o; t.rmask = rm; t.exp_vld = v; t.exp_bank = b; t.exp_cnt = c;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_valid(input logic [15:0] vm);
        for (int i = 0; i < 16; i++) bank_resp_valid[i] = vm[i];
    endtask

    function automatic logic [15:0] ready_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = bank_resp_ready[i];
        return m;
    endfunction

    task automatic chk_head(input string tag, input logic [3:0] b);
        chk({tag, " out_bank"},  32'(out_bank),  32'(b));
        chk({tag, " out_data"},  32'(out_data),  32'(m_data[b]));
        chk({tag, " out_index"}, 32'(out_index), 32'(m_index[b]));
        chk({tag, " out_type"},  32'(out_type),  32'(m_type[b]));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_type[i]  = 1'b0;
            m_data[i]  = 16'hC000 + 16'(i) * 16'h0101;
            m_index[i] = 6'(i + 8);
        end
        m_data[3] = 16'h000A; m_index[3] = 6'd5;
        m_type[9] = 1'b1;     m_index[9] = 6'd33; m_data[9] = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            bank_resp_type[i]  = m_type[i];
            bank_resp_data[i]  = m_data[i];
            bank_resp_index[i] = m_index[i];
        end

        // Simultaneous sources 0 and 15 from rr_ptr=0, then wrap.
        vecs.push_back(mk(16'h8001, 1, 16'h0001, 0, 0, 0));
        vecs.push_back(mk(16'h8000, 1, 16'h8000, 1, 0, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 15, 1));
        // Single read response from bank 3 (rr_ptr back at 0).
        vecs.push_back(mk(16'h0008, 1, 16'h0008, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 3, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 0, 0, 0));
        // Fairness: banks 1 and 2 held valid for six cycles, rr_ptr starts at 4.
        vecs.push_back(mk(16'h0006, 1, 16'h0002, 0, 0, 0));
        vecs.push_back(mk(16'h0006, 1, 16'h0004, 1, 1, 1));
        vecs.push_back(mk(16'h0006, 1, 16'h0002, 1, 2, 1));
        vecs.push_back(mk(16'h0006, 1, 16'h0004, 1, 1, 1));
        vecs.push_back(mk(16'h0006, 1, 16'h0002, 1, 2, 1));
        vecs.push_back(mk(16'h0006, 1, 16'h0004, 1, 1, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 2, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 0, 0, 0));
        // Backpressure: banks 4..8 with out_ready low, then release.
        vecs.push_back(mk(16'h01F0, 0, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(16'h01E0, 0, 16'h0020, 1, 4, 1));
        vecs.push_back(mk(16'h01C0, 0, 16'h0040, 1, 4, 2));
        vecs.push_back(mk(16'h0180, 0, 16'h0080, 1, 4, 3));
        vecs.push_back(mk(16'h0100, 0, 16'h0000, 1, 4, 4));
        vecs.push_back(mk(16'h0100, 0, 16'h0000, 1, 4, 4));
        vecs.push_back(mk(16'h0100, 1, 16'h0100, 1, 4, 4));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 5, 4));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 6, 3));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 7, 2));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 8, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 0, 0, 0));
        // Write ack from bank 9.
        vecs.push_back(mk(16'h0200, 1, 16'h0200, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 1, 9, 1));
        vecs.push_back(mk(16'h0000, 1, 16'h0000, 0, 0, 0));

        // Reset state.
        rst = 1'b0;
        out_ready = 1'b0;
        set_valid(16'h0000);
        #1;
        chk("reset out_valid",  32'(out_valid),  0);
        chk("reset fifo_count", 32'(fifo_count), 0);
        chk("reset fifo_full",  32'(fifo_full),  0);
        chk("reset ready",      32'(ready_mask()), 0);
        chk("reset out_data",   32'(out_data),   0);
        chk("reset out_bank",   32'(out_bank),   0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            set_valid(vecs[k].vmask);
            out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d ready", k),      32'(ready_mask()), 32'(vecs[k].rmask));
            chk($sformatf("v%0d out_valid", k),  32'(out_valid),    32'(vecs[k].exp_vld));
            chk($sformatf("v%0d fifo_count", k), 32'(fifo_count),   32'(vecs[k].exp_cnt));
            chk($sformatf("v%0d fifo_full", k),  32'(fifo_full),    32'(vecs[k].exp_cnt == 3'd4));
            if (vecs[k].exp_vld) chk_head($sformatf("v%0d", k), vecs[k].exp_bank);
        end

        // Reset mid-operation: load three entries (rr_ptr=10 so banks 0,1,2 are granted in order).
        out_ready = 1'b0;
        @(negedge clk); set_valid(16'h0007); #1;
        chk("rst_seq ready0", 32'(ready_mask()), 32'h0001);
        @(negedge clk); set_valid(16'h0006); #1;
        chk("rst_seq ready1", 32'(ready_mask()), 32'h0002);
        @(negedge clk); set_valid(16'h0004); #1;
        chk("rst_seq ready2", 32'(ready_mask()), 32'h0004);
        @(negedge clk); set_valid(16'h0020); #1;
        chk("rst_seq count3", 32'(fifo_count), 3);
        chk_head("rst_seq head", 4'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_seq out_valid", 32'(out_valid),    0);
        chk("rst_seq fifo_count", 32'(fifo_count),  0);
        chk("rst_seq ready",     32'(ready_mask()), 0);
        chk("rst_seq out_data",  32'(out_data),     0);
        @(negedge clk);
        set_valid(16'h0000);
        out_ready = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst%0d out_valid", c), 32'(out_valid),  0);
            chk($sformatf("post_rst%0d count", c),     32'(fifo_count), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
